mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared 64-bit memory port arbiter: IF/DM arbitration with an IF starvation guard,
// store lane alignment and byte masking, and load/fetch extraction from the 8-byte line.
package CorePack;
  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_op_enum;
  typedef logic [7:0] mask_t;
endpackage

module mem_port_arbiter
  import CorePack::*;
#(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_inst,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic              dm_req_we,
  input  mem_op_enum        dm_req_op,
  input  logic [63:0]       dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_resp_valid,
  output logic [63:0]       dm_resp_rdata,
  output logic              dm_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output mask_t             mem_wmask,
  output logic [63:0]       mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ERR = 2'd3} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic misaligned_f(input mem_op_enum op, input logic [2:0] off);
    case (op)
      MEM_H:   return off[0];
      MEM_W:   return off[1:0] != 2'd0;
      MEM_D:   return off != 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic mask_t wmask_f(input mem_op_enum op, input logic [2:0] off, input logic we);
    if (!we) return 8'h00;
    case (op)
      MEM_D:   return 8'hFF;
      MEM_W:   return 8'h0F << {off[2], 2'b00};
      MEM_H:   return 8'h03 << {off[2:1], 1'b0};
      default: return 8'h01 << off;
    endcase
  endfunction

  function automatic logic [63:0] load_extract_f(input mem_op_enum op, input logic [2:0] off,
                                                 input logic [63:0] line);
    logic [63:0] sh;
    sh = line >> {off, 3'b000};
    case (op)
      MEM_B:   return {56'h0, sh[7:0]};
      MEM_H:   return {48'h0, sh[15:0]};
      MEM_W:   return {32'h0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_dm_q, owner_dm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_op_enum        op_q, op_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              if_rv_q, if_rv_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              dm_rv_q, dm_rv_d;
  logic [63:0]       dm_rdata_q, dm_rdata_d;
  logic              dm_err_q, dm_err_d;

  logic dm_win_s, grant_dm_s, grant_if_s, issue_s;

  // DM has priority unless IF has waited through STARVE_LIMIT DM grants.
  assign dm_win_s   = dm_req_valid && (!if_req_valid || (starve_q != LIMIT));
  assign grant_dm_s = !rst && (state_q == IDLE) && dm_win_s;
  assign grant_if_s = !rst && (state_q == IDLE) && if_req_valid && !dm_win_s;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    owner_dm_d = owner_dm_q;
    addr_d     = addr_q;
    op_d       = op_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rv_d    = 1'b0;
    if_inst_d  = 32'h0;
    dm_rv_d    = 1'b0;
    dm_rdata_d = 64'h0;
    dm_err_d   = 1'b0;

    if (!if_req_valid || grant_if_s) begin
      starve_d = 4'd0;
    end else if (grant_dm_s && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      IDLE: begin
        if (grant_dm_s) begin
          owner_dm_d = 1'b1;
          addr_d     = dm_req_addr;
          op_d       = dm_req_op;
          we_d       = dm_req_we;
          wdata_d    = dm_req_we ? dm_req_wdata : 64'h0;
          // Misaligned requests report their error in the very next cycle.
          if (misaligned_f(dm_req_op, dm_req_addr[2:0])) begin
            state_d  = ERR;
            dm_rv_d  = 1'b1;
            dm_err_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end else if (grant_if_s) begin
          owner_dm_d = 1'b0;
          addr_d     = if_req_addr;
          op_d       = MEM_W;
          we_d       = 1'b0;
          wdata_d    = 64'h0;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = WAIT;
        else               state_d = ISSUE;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_dm_q) begin
            dm_rv_d    = 1'b1;
            dm_rdata_d = we_q ? 64'h0 : load_extract_f(op_q, addr_q[2:0], mem_rdata);
          end else begin
            if_rv_d   = 1'b1;
            if_inst_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else begin
          state_d = WAIT;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      owner_dm_q <= 1'b0;
      addr_q     <= '0;
      op_q       <= MEM_B;
      we_q       <= 1'b0;
      wdata_q    <= 64'h0;
      if_rv_q    <= 1'b0;
      if_inst_q  <= 32'h0;
      dm_rv_q    <= 1'b0;
      dm_rdata_q <= 64'h0;
      dm_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      owner_dm_q <= owner_dm_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rv_q    <= if_rv_d;
      if_inst_q  <= if_inst_d;
      dm_rv_q    <= dm_rv_d;
      dm_rdata_q <= dm_rdata_d;
      dm_err_q   <= dm_err_d;
    end
  end

  assign issue_s       = (state_q == ISSUE);
  assign if_req_ready  = grant_if_s;
  assign dm_req_ready  = grant_dm_s;
  assign mem_req_valid = issue_s;
  assign mem_addr      = issue_s ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wen       = issue_s & we_q;
  assign mem_wmask     = issue_s ? wmask_f(op_q, addr_q[2:0], we_q) : 8'h00;
  assign mem_wdata     = issue_s ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'h0;
  assign if_resp_valid = if_rv_q;
  assign if_resp_inst  = if_inst_q;
  assign dm_resp_valid = dm_rv_q;
  assign dm_resp_rdata = dm_rdata_q;
  assign dm_resp_err   = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory handshake driven by hand,
// expected values worked out from the port behaviour.
module tb_mem_port_arbiter;
  import CorePack::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        dm_req_valid;
  logic [63:0] dm_req_addr;
  logic        dm_req_we;
  mem_op_enum  dm_req_op;
  logic [63:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_resp_valid;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  mask_t       mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we),
    .dm_req_op(dm_req_op), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata), .dm_resp_err(dm_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_drive(input logic [63:0] a, input logic we, input mem_op_enum op,
                          input logic [63:0] wd);
    dm_req_valid = 1'b1;
    dm_req_addr  = a;
    dm_req_we    = we;
    dm_req_op    = op;
    dm_req_wdata = wd;
  endtask

  // From ISSUE: accept, then acknowledge with rdata; returns in the response cycle.
  task automatic mem_complete(input logic [63:0] rd);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    tick();
    mem_resp_valid = 1'b0;
    #1;
  endtask

  // Runs a full aligned DM transaction and checks the issued request and response.
  task automatic dm_txn(input string tag, input logic [63:0] a, input logic we,
                        input mem_op_enum op, input logic [63:0] wd, input logic [63:0] rd,
                        input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
    dm_drive(a, we, op, wd);
    #1;
    chk({tag, "_dm_ready"}, 64'(dm_req_ready), 64'd1);
    tick();
    dm_req_valid = 1'b0;
    #1;
    chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd1);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_mem_wen"}, 64'(mem_wen), 64'(we));
    chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'(exp_mask));
    if (we) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    mem_complete(rd);
    chk({tag, "_resp_valid"}, 64'(dm_resp_valid), 64'd1);
    chk({tag, "_resp_rdata"}, dm_resp_rdata, exp_rdata);
    chk({tag, "_resp_err"}, 64'(dm_resp_err), 64'd0);
    tick();
    chk({tag, "_resp_pulse_end"}, 64'(dm_resp_valid), 64'd0);
  endtask

  initial begin
    logic exp_dm [10];
    logic got_dm;
    bit   granted;

    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 64'h0;
    dm_req_valid = 1'b0; dm_req_addr = 64'h0; dm_req_we = 1'b0;
    dm_req_op = MEM_B; dm_req_wdata = 64'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    tick(); tick();
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_dm_resp", 64'(dm_resp_valid), 64'd0);
    chk("rst_if_resp", 64'(if_resp_valid), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    rst = 1'b0;
    tick();

    dm_txn("st_h", 64'h1006, 1'b1, MEM_H, 64'hABCD, 64'h0,
           64'h1000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0);
    dm_txn("ld_b", 64'h2003, 1'b0, MEM_B, 64'h0, 64'h1122_3344_5566_7788,
           64'h2000, 8'h00, 64'h0, 64'h55);
    dm_txn("st_w", 64'h5004, 1'b1, MEM_W, 64'hCAFE_BABE, 64'h0,
           64'h5000, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0);
    dm_txn("ld_h", 64'h6006, 1'b0, MEM_H, 64'h0, 64'h1122_3344_5566_7788,
           64'h6000, 8'h00, 64'h0, 64'h1122);

    // Instruction fetch from the upper word of the line.
    if_req_valid = 1'b1; if_req_addr = 64'h104;
    #1;
    chk("if_ready", 64'(if_req_ready), 64'd1);
    chk("if_dm_ready_low", 64'(dm_req_ready), 64'd0);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("if_mem_addr", mem_addr, 64'h100);
    chk("if_mem_wen", 64'(mem_wen), 64'd0);
    chk("if_mem_wmask", 64'(mem_wmask), 64'd0);
    mem_complete(64'hDEAD_BEEF_0000_0013);
    chk("if_resp_valid", 64'(if_resp_valid), 64'd1);
    chk("if_resp_inst", 64'(if_resp_inst), 64'hDEAD_BEEF);
    chk("if_no_dm_resp", 64'(dm_resp_valid), 64'd0);
    tick();
    chk("if_pulse_end", 64'(if_resp_valid), 64'd0);

    // Misaligned word load: error response without a memory request.
    dm_drive(64'h3002, 1'b0, MEM_W, 64'h0);
    #1;
    chk("mis_ready", 64'(dm_req_ready), 64'd1);
    tick();
    dm_req_valid = 1'b0;
    #1;
    chk("mis_resp_valid", 64'(dm_resp_valid), 64'd1);
    chk("mis_resp_err", 64'(dm_resp_err), 64'd1);
    chk("mis_resp_rdata", dm_resp_rdata, 64'h0);
    chk("mis_mem_valid", 64'(mem_req_valid), 64'd0);
    tick();
    chk("mis_pulse_end", 64'(dm_resp_valid), 64'd0);
    chk("mis_mem_valid2", 64'(mem_req_valid), 64'd0);
    chk("mis_err_low", 64'(dm_resp_err), 64'd0);

    // Both requesters valid continuously: four DM grants, then IF is forced.
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_req_valid = 1'b1; if_req_addr = 64'h200;
    dm_drive(64'h8000, 1'b0, MEM_D, 64'h0);
    #1;
    for (int g = 0; g < 10; g++) begin
      granted = 1'b0;
      got_dm  = 1'b0;
      for (int w = 0; w < 20 && !granted; w++) begin
        if (if_req_ready || dm_req_ready) begin
          granted = 1'b1;
          got_dm  = dm_req_ready;
          chk($sformatf("starve_one_ready_%0d", g), 64'(if_req_ready & dm_req_ready), 64'd0);
        end else begin
          tick();
        end
      end
      if (!granted) begin
        chk($sformatf("starve_grant_timeout_%0d", g), 64'd0, 64'd1);
        break;
      end
      chk($sformatf("starve_owner_%0d", g), 64'(got_dm), 64'(exp_dm[g]));
      tick();
      mem_complete(64'h0);
    end
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    tick(); tick();

    // Reset while waiting for the memory response.
    dm_drive(64'h9000, 1'b0, MEM_D, 64'h0);
    tick();
    dm_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rstw_in_wait", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 64'h5555_5555_5555_5555;
    #1;
    chk("rstw_dm_resp", 64'(dm_resp_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("rstw_no_dm_resp", 64'(dm_resp_valid), 64'd0);
    chk("rstw_no_if_resp", 64'(if_resp_valid), 64'd0);
    chk("rstw_mem_idle", 64'(mem_req_valid), 64'd0);
    tick();
    chk("rstw_no_dm_resp2", 64'(dm_resp_valid), 64'd0);

    dm_txn("post_rst_st_d", 64'h4008, 1'b1, MEM_D, 64'h0123_4567_89AB_CDEF, 64'h0,
           64'h4008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
    dm_txn("post_rst_ld_d", 64'h7000, 1'b0, MEM_D, 64'h0, 64'h1122_3344_5566_7788,
           64'h7000, 8'h00, 64'h0, 64'h1122_3344_5566_7788);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
